// File: rtl/inst_mem_loader_pkg.sv
// Shared state encodings and frame constants for the instruction memory loader.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_CHECK  = 3'd6
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_mem_loader_word_packer.sv
// Big-endian byte-to-word packer: shifts bytes into a 32-bit word, flags the 4th byte.
// word_ready is combinational with the shift of the final byte of a word.
module loader_word_packer
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= 32'd0;
      idx  <= 2'd0;
    end else if (clr) begin
      idx  <= 2'd0;
    end else if (shift_en) begin
      word <= {word[23:0], byte_in};
      idx  <= idx + 2'd1;
    end
  end

  assign word_ready = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit instruction memory writes; holds CPU until done.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] cnt_q;
  logic        err_q;
  logic        arm;
  logic        shift_en;
  logic        word_ready;
  logic        xfer;
  logic [15:0] len_full;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = rx_valid && rx_ready;
  assign len_full = {len_hi, rx_data};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    arm       = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          arm       = 1'b1;
          state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        rx_ready = 1'b1;
        if (xfer) begin
          if (len_full == 16'd0)                   state_nxt = ST_DONE;
          else if (len_full > 16'(DEPTH_WORDS))    state_nxt = ST_IDLE;
          else                                     state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        shift_en = xfer;
        if (word_ready) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (cnt_q + 16'd1 == len)
`ifdef INST_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        else
          state_nxt = ST_DATA;
      end
      ST_DONE: begin
        if (start) begin
          arm       = 1'b1;
          state_nxt = ST_LEN_HI;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        rx_ready = 1'b1;
        if (xfer) state_nxt = (rx_data == csum) ? ST_DONE : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length, word count and sticky error; later assignments take priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi <= 8'd0;
      len    <= 16'd0;
      cnt_q  <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (arm) begin
        cnt_q <= 16'd0;
        err_q <= 1'b0;
      end
      if (state == ST_LEN_HI && xfer) len_hi <= rx_data;
      if (state == ST_LEN_LO && xfer) begin
        len <= len_full;
        if (len_full > 16'(DEPTH_WORDS)) err_q <= 1'b1;
      end
      if (state == ST_WRITE) cnt_q <= cnt_q + 16'd1;
`ifdef INST_LOADER_CHECKSUM_EN
      if (state == ST_CHECK && xfer && rx_data != csum) err_q <= 1'b1;
`endif
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      csum <= 8'd0;
    else if (arm)
      csum <= 8'd0;
    else if (xfer && (state == ST_LEN_HI || state == ST_LEN_LO || state == ST_DATA))
      csum <= csum ^ rx_data;
  end
`endif

  loader_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (arm),
    .shift_en   (shift_en),
    .byte_in    (rx_data),
    .word       (wr_data),
    .word_ready (word_ready)
  );

  assign wr_en    = (state == ST_WRITE);
  assign wr_addr  = BASE_ADDR + {14'd0, cnt_q, 2'b00};
  assign cpu_hold = (state != ST_DONE);
  assign done     = (state == ST_DONE);
  assign err      = err_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader; checksum scenarios enabled with INST_LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;

  int vecs = 0;
  int miss = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  frame[$];
  logic [31:0] exp_a[2];
  logic [31:0] exp_d[2];

  always #5 clk = ~clk;

  inst_mem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns #1 after the edge on which the byte was transferred.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    int n;
    gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    rx_valid = 1'b0;
    rx_data  = 8'hEE;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (rx_ready !== 1'b1) begin
      vecs++; miss++;
      $display("FAIL send_byte_timeout rx_ready=%b want 1", rx_ready);
    end else begin
      tick();
    end
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x;
    x = 8'h00;
    foreach (frame[i]) x ^= frame[i];
    return x;
  endfunction

  // Ends in DONE (or IDLE on a checksum mismatch / length error).
  task automatic send_frame(input int gapmax, input logic [7:0] csum_flip);
    foreach (frame[i]) send_byte(frame[i], gapmax);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(frame_xor() ^ csum_flip, gapmax);
`else
    if (csum_flip != 8'h00) $display("note: checksum flip ignored in this build");
    tick();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick();
    start = 1'b1;
    tick();
    vecs++; if (rx_ready !== 1'b0 || wr_en !== 1'b0) begin miss++; $display("FAIL reset_strobes rx_ready=%b wr_en=%b want 0 0", rx_ready, wr_en); end
    vecs++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin miss++; $display("FAIL reset_bus wr_addr=%h wr_data=%h want 0 0", wr_addr, wr_data); end
    vecs++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin miss++; $display("FAIL reset_status hold=%b done=%b err=%b want 1 0 0", cpu_hold, done, err); end
    vecs++; if (word_cnt !== 16'd0) begin miss++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt); end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    vecs++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin miss++; $display("FAIL reset_start_ignored rx_ready=%b hold=%b want 0 1", rx_ready, cpu_hold); end
  endtask

  task automatic test_basic();
    log_addr.delete(); log_data.delete();
    pulse_start();
    vecs++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin miss++; $display("FAIL basic_armed rx_ready=%b hold=%b want 1 1", rx_ready, cpu_hold); end
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    vecs++; if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'h3C01_0010) begin miss++; $display("FAIL basic_first_write en=%b addr=%h data=%h want 1 00000000 3c010010", wr_en, wr_addr, wr_data); end
    for (int i = 6; i < 10; i++) send_byte(frame[i], 0);
    vecs++; if (wr_en !== 1'b1 || wr_addr !== 32'h4 || wr_data !== 32'h3421_0004) begin miss++; $display("FAIL basic_second_write en=%b addr=%h data=%h want 1 00000004 34210004", wr_en, wr_addr, wr_data); end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(frame_xor(), 0);
`else
    tick();
`endif
    vecs++; if (done !== 1'b1 || cpu_hold !== 1'b0 || word_cnt !== 16'd2) begin miss++; $display("FAIL basic_done done=%b hold=%b cnt=%0d want 1 0 2", done, cpu_hold, word_cnt); end
    vecs++; if (log_addr.size() != 2) begin miss++; $display("FAIL basic_write_count got %0d want 2", log_addr.size()); end
    else for (int i = 0; i < 2; i++) if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i]) begin
      miss++; $display("FAIL basic_log[%0d] got %h:%h want %h:%h", i, log_addr[i], log_data[i], exp_a[i], exp_d[i]);
    end
  endtask

  task automatic test_random_valid();
    log_addr.delete(); log_data.delete();
    pulse_start();
    vecs++; if (done !== 1'b0 || cpu_hold !== 1'b1 || word_cnt !== 16'd0) begin miss++; $display("FAIL reload_rearm done=%b hold=%b cnt=%0d want 0 1 0", done, cpu_hold, word_cnt); end
    send_frame(3, 8'h00);
    vecs++; if (done !== 1'b1 || err !== 1'b0) begin miss++; $display("FAIL random_done done=%b err=%b want 1 0", done, err); end
    vecs++; if (log_addr.size() != 2) begin miss++; $display("FAIL random_write_count got %0d want 2", log_addr.size()); end
    else for (int i = 0; i < 2; i++) if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i]) begin
      miss++; $display("FAIL random_log[%0d] got %h:%h want %h:%h", i, log_addr[i], log_data[i], exp_a[i], exp_d[i]);
    end
  endtask

  task automatic test_length_limits();
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    vecs++; if (err !== 1'b0 || rx_ready !== 1'b1) begin miss++; $display("FAIL len_64_accepted err=%b rx_ready=%b want 0 1", err, rx_ready); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    vecs++; if (err !== 1'b1 || rx_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL len_65_err err=%b rx_ready=%b hold=%b done=%b want 1 0 1 0", err, rx_ready, hold_dummy(), done); end
    repeat (3) tick();
    vecs++; if (err !== 1'b1 || log_addr.size() != 0) begin miss++; $display("FAIL len_65_sticky err=%b writes=%0d want 1 0", err, log_addr.size()); end
    pulse_start();
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL start_clears_err got %b want 0", err); end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    vecs++; if (done !== 1'b1 || cpu_hold !== 1'b0 || word_cnt !== 16'd0 || log_addr.size() != 0) begin miss++; $display("FAIL len_zero done=%b hold=%b cnt=%0d writes=%0d want 1 0 0 0", done, cpu_hold, word_cnt, log_addr.size()); end
  endtask

  function automatic logic hold_dummy();
    return cpu_hold;
  endfunction

  task automatic test_abort();
    log_addr.delete(); log_data.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    pulse_start();
    for (int i = 4; i < 8; i++) send_byte(frame[i], 0);
    vecs++; if (log_addr.size() != 1 || log_data[0] !== 32'h3C01_0010) begin miss++; $display("FAIL abort_first_write writes=%0d want 1 of 3c010010", log_addr.size()); end
    rst_n = 1'b0;
    tick();
    vecs++; if (wr_en !== 1'b0 || rx_ready !== 1'b0 || cpu_hold !== 1'b1 || word_cnt !== 16'd0) begin miss++; $display("FAIL abort_reset en=%b rx_ready=%b hold=%b cnt=%0d want 0 0 1 0", wr_en, rx_ready, cpu_hold, word_cnt); end
    rst_n = 1'b1;
    repeat (3) tick();
    vecs++; if (log_addr.size() != 1 || rx_ready !== 1'b0) begin miss++; $display("FAIL abort_no_partial writes=%0d rx_ready=%b want 1 0", log_addr.size(), rx_ready); end
    pulse_start();
    send_frame(0, 8'h00);
    vecs++; if (done !== 1'b1 || word_cnt !== 16'd2) begin miss++; $display("FAIL abort_reload done=%b cnt=%0d want 1 2", done, word_cnt); end
    vecs++; if (log_addr.size() != 3) begin miss++; $display("FAIL abort_reload_count got %0d want 3", log_addr.size()); end
    else for (int i = 0; i < 2; i++) if (log_addr[i+1] !== exp_a[i] || log_data[i+1] !== exp_d[i]) begin
      miss++; $display("FAIL abort_reload_log[%0d] got %h:%h want %h:%h", i, log_addr[i+1], log_data[i+1], exp_a[i], exp_d[i]);
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_frame(0, 8'h01);
    vecs++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin miss++; $display("FAIL csum_bad err=%b done=%b hold=%b rx_ready=%b want 1 0 1 0", err, done, cpu_hold, rx_ready); end
    vecs++; if (log_addr.size() != 2) begin miss++; $display("FAIL csum_bad_writes got %0d want 2", log_addr.size()); end
    pulse_start();
    send_frame(0, 8'h00);
    vecs++; if (err !== 1'b0 || done !== 1'b1) begin miss++; $display("FAIL csum_good err=%b done=%b want 0 1", err, done); end
  endtask
`endif

  initial begin
    frame = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h34, 8'h21, 8'h00, 8'h04};
    exp_a = '{32'h0000_0000, 32'h0000_0004};
    exp_d = '{32'h3C01_0010, 32'h3421_0004};
    test_reset();
    test_basic();
    test_random_valid();
    test_length_limits();
    test_abort();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
